// File: rtl/snes_pad_responder.sv
// snes_pad_responder: the device side of an SNES-style joystick link. Twelve
// debounced local buttons are latched into a 16-bit frame on the host's
// strobe and shifted out one bit per host clock rising edge. The serial data
// is active low.
//
// Ports:
//   clk         block clock (clk4 domain)
//   reset_n     asynchronous active-low reset
//   pad_strobe  host latch line, async, active high
//   pad_clock   host shift clock, async, idles high
//   pad_data    serial data to host, 0 = pressed
//   buttons     raw button levels, 1 = pressed
//               bit order from 0: B Y Sel Start Up Down Left Right A X L R
//   turbo_sel   bit 0 enables turbo on B, bit 1 enables turbo on A
//   bit_count   bits shifted since the last latch, saturates at 16
//   frame_done  one-cycle pulse on the 16th shift
//
// Optional feature: define SNES_PAD_TURBO_EN to build the turbo phase logic.
// Without it, turbo_sel is ignored.
module snes_pad_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16384,
    parameter int unsigned TURBO_FRAMES    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pad_strobe,
    input  logic        pad_clock,
    output logic        pad_data,
    input  logic [11:0] buttons,
    input  logic [1:0]  turbo_sel,
    output logic [4:0]  bit_count,
    output logic        frame_done
);

    localparam int unsigned NUM_BTN = 12;
    localparam int unsigned SR_W    = 16;
    localparam int unsigned BC_W    = 5;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BC_W-1:0] BC_FULL  = BC_W'(SR_W);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(SR_W - 1);

    typedef enum logic {
        ST_LATCH = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Synchronizer chains: [0] and [1] synchronize, and [2] holds history for edge detection.
    logic [2:0] stb_q;
    logic [2:0] pck_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stb_q <= 3'b000;
            pck_q <= 3'b111;
        end else begin
            stb_q <= {stb_q[1:0], pad_strobe};
            pck_q <= {pck_q[1:0], pad_clock};
        end
    end

    logic stb_sync;
    logic stb_fall;
    logic pck_rise;

    assign stb_sync = stb_q[1];
    assign stb_fall = ~stb_q[1] & stb_q[2];
    assign pck_rise = pck_q[1] & ~pck_q[2];

    // Per-button debounce: the accepted level follows raw only after a stable run.
    logic [NUM_BTN-1:0] db_q;
    logic [NUM_BTN-1:0] db_d;
    logic [DB_W-1:0]    cnt_q [NUM_BTN];
    logic [DB_W-1:0]    cnt_d [NUM_BTN];

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt_d[i] = '0;
            if (buttons[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = buttons[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Effective button levels presented to the latch.
    logic [NUM_BTN-1:0] eff;

`ifdef SNES_PAD_TURBO_EN
    localparam int unsigned TP_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
    localparam logic [TP_W-1:0] TP_LAST = TP_W'(TURBO_FRAMES - 1);

    logic [TP_W-1:0] phase_q;
    logic            tp_q;

    // Turbo phase flips once every TURBO_FRAMES strobe falling edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            tp_q    <= 1'b0;
        end else if (stb_fall) begin
            if (phase_q == TP_LAST) begin
                phase_q <= '0;
                tp_q    <= ~tp_q;
            end else begin
                phase_q <= phase_q + TP_W'(1);
            end
        end
    end

    always_comb begin
        eff    = db_q;
        eff[0] = db_q[0] & ~(turbo_sel[0] & tp_q);
        eff[8] = db_q[8] & ~(turbo_sel[1] & tp_q);
    end
`else
    logic unused_turbo;

    assign eff          = db_q;
    assign unused_turbo = ^turbo_sel;
`endif

    // Latch/shift FSM. A held strobe keeps reloading, so strobe wins over a coincident clock edge.
    state_e            state_q;
    logic [SR_W-1:0]   sr_q;
    logic              pad_data_q;
    logic [BC_W-1:0]   bit_count_q;
    logic              frame_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SHIFT;
            sr_q         <= '0;
            pad_data_q   <= 1'b1;
            bit_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (stb_sync) begin
                state_q     <= ST_LATCH;
                sr_q        <= {4'b0000, eff};
                pad_data_q  <= ~eff[0];
                bit_count_q <= '0;
            end else if (state_q == ST_LATCH) begin
                // sr keeps the last load, so B is already on pad_data.
                if (stb_fall) begin
                    state_q <= ST_SHIFT;
                end
            end else if (pck_rise) begin
                // Ones shift in from the top, so an over-clocked frame reads pressed (0).
                sr_q       <= {1'b1, sr_q[SR_W-1:1]};
                pad_data_q <= ~sr_q[1];
                if (bit_count_q != BC_FULL) begin
                    bit_count_q <= bit_count_q + BC_W'(1);
                end
                if (bit_count_q == BC_LAST) begin
                    frame_done_q <= 1'b1;
                end
            end
        end
    end

    assign pad_data   = pad_data_q;
    assign bit_count  = bit_count_q;
    assign frame_done = frame_done_q;

endmodule
